// File: rtl/fetch_buf_pkg.sv
// -----------------------------------------------------------------------------
// fetch_buf_pkg
// Shared constants and types for the instruction fetch buffer:
//   FB_INST_BYTES - decoder window width in bytes
//   FB_BUF_BYTES  - byte queue capacity
//   FB_INST_W     - width of the instruction bus presented to the decoder
//   fetchStateT   - ROM request tracker states
// -----------------------------------------------------------------------------
package fetch_buf_pkg;

    localparam int FB_INST_BYTES = 10;
    localparam int FB_BUF_BYTES  = 16;
    localparam int FB_INST_W     = FB_INST_BYTES * 8;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        STALE = 2'd2
    } fetchStateT;

endpackage

// File: rtl/fetch_byteq.sv
// -----------------------------------------------------------------------------
// fetch_byteq
// Byte queue behind the fetch buffer. Byte 0 is the byte at the current base
// address. Each cycle the queue can drop bytes from the head and append the
// useful bytes of one ROM word at the tail; a clear empties it.
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   clear      - empty the queue (redirect)
//   drop       - number of head bytes to discard this cycle
//   append     - append bytes skip..3 of data this cycle
//   data       - ROM word, little-endian ([7:0] is the lowest address)
//   skip       - number of low bytes of data to ignore
//   count      - bytes currently held
//   window     - bytes 0..INST_BYTES-1, byte 0 in the most significant lane
// -----------------------------------------------------------------------------
module fetch_byteq
    import fetch_buf_pkg::*;
#(
    parameter int INST_BYTES = FB_INST_BYTES,
    parameter int BUF_BYTES  = FB_BUF_BYTES,
    localparam int CW        = $clog2(BUF_BYTES + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic [CW-1:0]           drop,
    input  logic                    append,
    input  logic [31:0]             data,
    input  logic [1:0]              skip,
    output logic [CW-1:0]           count,
    output logic [INST_BYTES*8-1:0] window
);

    localparam int QW = BUF_BYTES * 8;

    // Bytes at positions >= count are kept at zero at all times, so the read
    // window needs no masking and a right shift alone performs the drop.
    logic [QW-1:0] qVec;
    logic [QW-1:0] shifted;
    logic [QW-1:0] appendVec;
    logic [QW-1:0] qNext;
    logic [CW-1:0] keep;
    logic [2:0]    appendN;
    logic [CW-1:0] countNext;

    always_comb begin
        keep      = count - drop;
        shifted   = qVec >> {drop, 3'b000};
        appendVec = '0;
        appendN   = 3'd0;
        if (append) begin
            appendN   = 3'd4 - {1'b0, skip};
            appendVec = QW'(data >> {skip, 3'b000}) << {keep, 3'b000};
        end
        qNext     = shifted | appendVec;
        countNext = keep + CW'(appendN);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            qVec  <= '0;
            count <= '0;
        end else begin
            qVec  <= qNext;
            count <= countNext;
        end
    end

    always_comb begin
        window = '0;
        for (int i = 0; i < INST_BYTES; i++) begin
            window[(INST_BYTES-1-i)*8 +: 8] = qVec[i*8 +: 8];
        end
    end

endmodule

// File: rtl/fetch_buf.sv
// -----------------------------------------------------------------------------
// fetch_buf
// Instruction fetch buffer between a word-wide ROM and a decoder that asks for
// a 10-byte window at an arbitrary byte address. Keeps a contiguous byte queue
// starting at base, prefetches ROM words with at most one request outstanding
// and restarts the stream when the decoder jumps outside the queued range.
//
// Optional feature: define FETCH_STALL_CNT_EN to count cycles where the decoder
// requests but no complete window is available. Without it stall_cnt_o is 0.
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   pc_i, req_i   - decoder byte address and its valid
//   inst_o        - window pc_i..pc_i+9, pc_i byte in the top lane
//   inst_valid_o  - inst_o is complete for pc_i
//   mem_req_o     - one-cycle ROM read request at mem_addr_o (word aligned)
//   mem_data_i    - ROM word, qualified by mem_valid_i
//   stall_cnt_o   - saturating stall counter (see macro above)
//
// state | meaning
// RUN   | no ROM request outstanding
// WAIT  | request outstanding, data belongs to the current stream
// STALE | request outstanding, issued before a redirect; data is dropped
// -----------------------------------------------------------------------------
module fetch_buf
    import fetch_buf_pkg::*;
#(
    parameter int INST_BYTES = FB_INST_BYTES,
    parameter int BUF_BYTES  = FB_BUF_BYTES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             pc_i,
    input  logic                    req_i,
    output logic [INST_BYTES*8-1:0] inst_o,
    output logic                    inst_valid_o,
    output logic                    mem_req_o,
    output logic [31:0]             mem_addr_o,
    input  logic [31:0]             mem_data_i,
    input  logic                    mem_valid_i,
    output logic [31:0]             stall_cnt_o
);

    localparam int CW = $clog2(BUF_BYTES + 1);

    fetchStateT    state;
    logic [31:0]   base;
    logic [31:0]   fetchAddr;
    logic [1:0]    skip;
    logic [CW-1:0] count;

    logic [31:0]   offset;
    logic          inRange;
    logic          redirect;
    logic [CW-1:0] drop;
    logic          respIn;
    logic          respAccept;
    logic [31:0]   appendN;
    logic [31:0]   postCount;
    logic          reqFire;

    always_comb begin
        offset     = pc_i - base;
        // Unsigned compare: addresses below base wrap to huge offsets and
        // fall out of range, which is exactly a redirect.
        inRange    = req_i && (offset <= 32'(count));
        redirect   = req_i && !inRange;
        drop       = inRange ? offset[CW-1:0] : '0;
        respIn     = (state == WAIT) && mem_valid_i;
        // A redirect in the response cycle wins; that word is thrown away.
        respAccept = respIn && !redirect;
        appendN    = respAccept ? (32'd4 - 32'(skip)) : 32'd0;
        postCount  = 32'(count) - 32'(drop) + appendN;
        // Only request when a full word is guaranteed to fit on arrival:
        // count can only shrink while the request is outstanding.
        reqFire    = !rst && !redirect && ((state == RUN) || respIn) &&
                     (postCount <= 32'(BUF_BYTES - 4));
    end

    assign mem_req_o    = reqFire;
    assign mem_addr_o   = rst ? 32'd0 : fetchAddr;
    assign inst_valid_o = req_i && (pc_i == base) && (32'(count) >= 32'(INST_BYTES));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            base      <= 32'd0;
            fetchAddr <= 32'd0;
            skip      <= 2'd0;
        end else begin
            if (redirect) begin
                base      <= pc_i;
                fetchAddr <= {pc_i[31:2], 2'b00};
                skip      <= pc_i[1:0];
            end else begin
                if (inRange) begin
                    base <= pc_i;
                end
                if (respAccept) begin
                    skip <= 2'd0;
                end
                if (reqFire) begin
                    fetchAddr <= fetchAddr + 32'd4;
                end
            end

            case (state)
                RUN: begin
                    if (reqFire) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_valid_i) begin
                        state <= reqFire ? WAIT : RUN;
                    end else if (redirect) begin
                        state <= STALE;
                    end
                end
                STALE: begin
                    if (mem_valid_i) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    fetch_byteq #(
        .INST_BYTES (INST_BYTES),
        .BUF_BYTES  (BUF_BYTES)
    ) uByteq (
        .clk    (clk),
        .rst    (rst),
        .clear  (redirect),
        .drop   (drop),
        .append (respAccept),
        .data   (mem_data_i),
        .skip   (skip),
        .count  (count),
        .window (inst_o)
    );

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stallCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt <= 32'd0;
        end else if (req_i && !inst_valid_o && (stallCnt != 32'hFFFF_FFFF)) begin
            stallCnt <= stallCnt + 32'd1;
        end
    end

    assign stall_cnt_o = stallCnt;
`else
    assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_buf.sv
module tb_fetch_buf;
    import fetch_buf_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [31:0]          pc_i;
    logic                 req_i;
    logic [FB_INST_W-1:0] inst_o;
    logic                 inst_valid_o;
    logic                 mem_req_o;
    logic [31:0]          mem_addr_o;
    logic [31:0]          mem_data_i;
    logic                 mem_valid_i;
    logic [31:0]          stall_cnt_o;

    fetch_buf dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .req_i        (req_i),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_i   (mem_data_i),
        .mem_valid_i  (mem_valid_i),
        .stall_cnt_o  (stall_cnt_o)
    );

    always #5 clk = ~clk;

`ifdef FETCH_STALL_CNT_EN
    localparam logic [31:0] STALL5 = 32'd5;
`else
    localparam logic [31:0] STALL5 = 32'd0;
`endif

    int checks = 0;
    int errors = 0;
    bit quiet  = 1'b0;

    // ROM responder
    int          curLat  = 1;
    int          pendLeft = 0;
    logic [31:0] pendAddr = 32'd0;

    // Reference model: byte queue plus request bookkeeping
    logic [7:0]  mq[$];
    logic [31:0] mBase  = 32'd0;
    logic [31:0] mFetch = 32'd0;
    logic [1:0]  mSkip  = 2'd0;
    bit          mBusy  = 1'b0;
    bit          mStale = 1'b0;
    logic [31:0] mStall = 32'd0;

    typedef struct {
        logic        req;
        logic [31:0] pc;
        logic        expReq;
        logic [31:0] expAddr;
        logic        expValid;
    } vecT;

    vecT tbl[5];

    function automatic logic [7:0] romByte(input logic [31:0] a);
        logic [31:0] t;
        t = a * 32'd37 + 32'd11;
        return t[7:0] ^ a[15:8];
    endfunction

    function automatic logic [31:0] romWord(input logic [31:0] a);
        return {romByte(a + 32'd3), romByte(a + 32'd2), romByte(a + 32'd1), romByte(a)};
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // One clock cycle: drive inputs, compare outputs against the model, advance the model.
    task automatic cycle(input logic rq, input logic [31:0] pc, input logic rs);
        logic [79:0] expWin;
        logic [31:0] off;
        logic        inRange, redir, respHere, accept, expValid, expReq;
        int          size, dropN, addN;
        @(negedge clk);
        rst         = rs;
        req_i       = rq;
        pc_i        = pc;
        mem_valid_i = 1'b0;
        mem_data_i  = $urandom;
        if (pendLeft > 0) begin
            pendLeft--;
            if (pendLeft == 0) begin
                mem_valid_i = 1'b1;
                mem_data_i  = romWord(pendAddr);
            end
        end
        if (rs) pendLeft = 0;
        #1;
        size   = mq.size();
        expWin = '0;
        for (int i = 0; i < FB_INST_BYTES; i++) begin
            if (i < size) expWin[(FB_INST_BYTES-1-i)*8 +: 8] = mq[i];
        end
        expValid = rq && (pc == mBase) && (size >= FB_INST_BYTES);
        off      = pc - mBase;
        inRange  = rq && (off <= 32'(size));
        redir    = rq && !inRange;
        dropN    = inRange ? int'(off) : 0;
        respHere = mBusy && mem_valid_i && !rs;
        accept   = respHere && !mStale && !redir;
        addN     = accept ? 4 - int'(mSkip) : 0;
        expReq   = !rs && !redir && (!mBusy || (respHere && !mStale)) &&
                   (size - dropN + addN <= FB_BUF_BYTES - 4);
        if (!quiet) begin
            check("stall_cnt_o", 80'(stall_cnt_o), 80'(mStall));
            check("inst_o", inst_o, expWin);
            check("inst_valid_o", 80'(inst_valid_o), 80'(expValid));
            check("mem_req_o", 80'(mem_req_o), 80'(expReq));
            if (expReq || rs) check("mem_addr_o", 80'(mem_addr_o), rs ? 80'd0 : 80'(mFetch));
        end
`ifdef FETCH_STALL_CNT_EN
        if (rq && !expValid && (mStall != 32'hFFFF_FFFF)) mStall = mStall + 32'd1;
`endif
        if (rs) begin
            mq.delete();
            mBase  = 32'd0;
            mFetch = 32'd0;
            mSkip  = 2'd0;
            mBusy  = 1'b0;
            mStale = 1'b0;
            mStall = 32'd0;
        end else begin
            if (redir) begin
                mq.delete();
                mBase  = pc;
                mFetch = {pc[31:2], 2'b00};
                mSkip  = pc[1:0];
            end else begin
                for (int k = 0; k < dropN; k++) void'(mq.pop_front());
                if (inRange) mBase = pc;
                if (accept) begin
                    for (int k = int'(mSkip); k < 4; k++) mq.push_back(mem_data_i[8*k +: 8]);
                    mSkip = 2'd0;
                end
            end
            if (respHere) begin
                mBusy  = 1'b0;
                mStale = 1'b0;
            end else if (mBusy && redir) begin
                mStale = 1'b1;
            end
            if (expReq) begin
                mBusy  = 1'b1;
                mStale = 1'b0;
                mFetch = mFetch + 32'd4;
            end
        end
        if (!rs && mem_req_o) begin
            pendLeft = curLat;
            pendAddr = mem_addr_o;
        end
    endtask

    task automatic doReset();
        quiet = (checks == 0);
        cycle(1'b0, 32'd0, 1'b1);
        quiet = 1'b0;
        cycle(1'b0, 32'd0, 1'b1);
    endtask

    initial begin
        logic [79:0] win031;
        rst = 1'b1; req_i = 1'b0; pc_i = 32'd0; mem_valid_i = 1'b0; mem_data_i = 32'd0;

        tbl[0] = '{1'b1, 32'd0, 1'b1, 32'd0,  1'b0};
        tbl[1] = '{1'b1, 32'd0, 1'b1, 32'd4,  1'b0};
        tbl[2] = '{1'b1, 32'd0, 1'b1, 32'd8,  1'b0};
        tbl[3] = '{1'b1, 32'd0, 1'b1, 32'd12, 1'b0};
        tbl[4] = '{1'b1, 32'd0, 1'b0, 32'd16, 1'b1};

        // Reset state
        doReset();
        settle();
        check("rst_base", 80'(dut.base), 80'd0);
        check("rst_count", 80'(dut.uByteq.count), 80'd0);
        check("rst_state", 80'(dut.state), 80'(RUN));
        check("rst_fetch", 80'(dut.fetchAddr), 80'd0);

        // Sequential fetch from 0 with a 1-cycle ROM
        curLat = 1;
        for (int i = 0; i < 5; i++) begin
            cycle(tbl[i].req, tbl[i].pc, 1'b0);
            check("t031_req", 80'(mem_req_o), 80'(tbl[i].expReq));
            if (tbl[i].expReq) check("t031_addr", 80'(mem_addr_o), 80'(tbl[i].expAddr));
            check("t031_valid", 80'(inst_valid_o), 80'(tbl[i].expValid));
        end
        win031 = '0;
        for (int i = 0; i < 10; i++) win031[(9-i)*8 +: 8] = romByte(32'(i));
        check("t031_inst", inst_o, win031);

        // Stepping pc through a full queue: 0 -> 2 -> 12
        cycle(1'b1, 32'd0, 1'b0);
        settle();
        check("t033_full", 80'(dut.uByteq.count), 80'd16);
        cycle(1'b1, 32'd2, 1'b0);
        check("t033_noreq", 80'(mem_req_o), 80'd0);
        settle();
        check("t033_base2", 80'(dut.base), 80'd2);
        check("t033_cnt14", 80'(dut.uByteq.count), 80'd14);
        cycle(1'b1, 32'd12, 1'b0);
        settle();
        check("t033_base12", 80'(dut.base), 80'd12);
        check("t033_cnt4", 80'(dut.uByteq.count), 80'd4);

        // Full queue holds off requests until count drops to 12
        doReset();
        curLat = 1;
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'd0, 1'b0);
            check("t035_hold", 80'(mem_req_o), 80'd0);
        end
        cycle(1'b1, 32'd3, 1'b0);
        check("t035_cnt13", 80'(mem_req_o), 80'd0);
        cycle(1'b1, 32'd4, 1'b0);
        check("t035_cnt12", 80'(mem_req_o), 80'd1);
        check("t035_addr", 80'(mem_addr_o), 80'd16);

        // Unaligned redirect to 0x13
        doReset();
        curLat = 1;
        cycle(1'b1, 32'h13, 1'b0);
        check("t032_c0req", 80'(mem_req_o), 80'd0);
        cycle(1'b1, 32'h13, 1'b0);
        check("t032_c1req", 80'(mem_req_o), 80'd1);
        check("t032_c1addr", 80'(mem_addr_o), 80'h10);
        cycle(1'b1, 32'h13, 1'b0);
        settle();
        check("t032_onebyte", 80'(dut.uByteq.count), 80'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'h13, 1'b0);
            check("t032_notyet", 80'(inst_valid_o), 80'd0);
        end
        cycle(1'b1, 32'h13, 1'b0);
        check("t032_valid", 80'(inst_valid_o), 80'd1);
        check("t032_byte0", 80'(inst_o[79:72]), 80'(romByte(32'h13)));
        check("t032_byte1", 80'(inst_o[71:64]), 80'(romByte(32'h14)));

        // Redirect while a 3-cycle ROM read is outstanding
        doReset();
        curLat = 3;
        cycle(1'b1, 32'd0, 1'b0);
        check("t034_req0", 80'(mem_req_o), 80'd1);
        cycle(1'b1, 32'h40, 1'b0);
        settle();
        check("t034_stale", 80'(dut.state), 80'(STALE));
        cycle(1'b1, 32'h40, 1'b0);
        check("t034_noreq", 80'(mem_req_o), 80'd0);
        cycle(1'b1, 32'h40, 1'b0);
        check("t034_drop_req", 80'(mem_req_o), 80'd0);
        settle();
        check("t034_discard", 80'(dut.uByteq.count), 80'd0);
        check("t034_run", 80'(dut.state), 80'(RUN));
        cycle(1'b1, 32'h40, 1'b0);
        check("t034_newreq", 80'(mem_req_o), 80'd1);
        check("t034_newaddr", 80'(mem_addr_o), 80'h40);

        // Reset while a read is in flight: its response is ignored
        doReset();
        curLat = 1;
        cycle(1'b1, 32'd0, 1'b0);
        cycle(1'b1, 32'd0, 1'b1);
        settle();
        check("t026_count", 80'(dut.uByteq.count), 80'd0);
        check("t026_state", 80'(dut.state), 80'(RUN));

        // Stall counter
        doReset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h13, 1'b0);
        cycle(1'b0, 32'd0, 1'b0);
        check("t036_five", 80'(stall_cnt_o), 80'(STALL5));
        cycle(1'b0, 32'd0, 1'b1);
        cycle(1'b0, 32'd0, 1'b0);
        check("t036_rst", 80'(stall_cnt_o), 80'd0);

        // Randomized traffic against the model
        doReset();
        for (int n = 0; n < 3000; n++) begin
            int          r;
            logic [31:0] pc;
            logic        rq, rs;
            curLat = int'($urandom_range(1, 3));
            r = int'($urandom_range(0, 99));
            if (r < 5)       pc = $urandom;
            else if (r < 8)  pc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            else if (r < 12) pc = mBase + 32'(mq.size()) + 32'd1 + $urandom_range(0, 3);
            else if (r < 60) pc = mBase;
            else             pc = mBase + $urandom_range(0, mq.size());
            rq = ($urandom_range(0, 9) != 0);
            rs = ($urandom_range(0, 199) == 0);
            cycle(rq, pc, rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
